// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: three-master Wishbone arbiter with ownership lock and stall watchdog.
// Define WB_ARB_RR_EN for round-robin arbitration; fixed priority m0 > m1 > m2 otherwise.
module wb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        m0_wb_cyc,
    input  logic        m0_wb_stb,
    input  logic        m0_wb_we,
    input  logic [23:0] m0_wb_adr,
    input  logic [15:0] m0_wb_o_dat,
    input  logic [1:0]  m0_wb_sel,
    input  logic        m0_wb_4_burst,
    input  logic        m0_wb_8_burst,
    output logic [15:0] m0_wb_i_dat,
    output logic        m0_wb_ack,
    output logic        m0_wb_err,
    input  logic        m1_wb_cyc,
    input  logic        m1_wb_stb,
    input  logic        m1_wb_we,
    input  logic [23:0] m1_wb_adr,
    input  logic [15:0] m1_wb_o_dat,
    input  logic [1:0]  m1_wb_sel,
    input  logic        m1_wb_4_burst,
    input  logic        m1_wb_8_burst,
    output logic [15:0] m1_wb_i_dat,
    output logic        m1_wb_ack,
    output logic        m1_wb_err,
    input  logic        m2_wb_cyc,
    input  logic        m2_wb_stb,
    input  logic        m2_wb_we,
    input  logic [23:0] m2_wb_adr,
    input  logic [15:0] m2_wb_o_dat,
    input  logic [1:0]  m2_wb_sel,
    input  logic        m2_wb_4_burst,
    input  logic        m2_wb_8_burst,
    output logic [15:0] m2_wb_i_dat,
    output logic        m2_wb_ack,
    output logic        m2_wb_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic        wb_4_burst,
    output logic        wb_8_burst,
    output logic [23:0] wb_adr,
    output logic [15:0] wb_o_dat,
    output logic [1:0]  wb_sel,
    input  logic [15:0] wb_i_dat,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic [1:0]  o_owner
);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t state_q, state_d;
    logic [1:0] owner_q, owner_d, win;
    logic [7:0] wdog_q, wdog_d;
    logic [3:0] req;
    logic cyc_a[4], stb_a[4], we_a[4], b4_a[4], b8_a[4];
    logic [23:0] adr_a[4];
    logic [15:0] dat_a[4];
    logic [1:0] sel_a[4];
    logic own, sel_cyc, sel_stb, timeout;
    logic [2:0] ack_v, err_v;
    // Slot 3 is a dummy so the 2-bit owner index never falls outside the arrays.
    assign req   = {1'b0, m2_wb_cyc, m1_wb_cyc, m0_wb_cyc};
    assign cyc_a = '{m0_wb_cyc, m1_wb_cyc, m2_wb_cyc, 1'b0};
    assign stb_a = '{m0_wb_stb, m1_wb_stb, m2_wb_stb, 1'b0};
    assign we_a  = '{m0_wb_we, m1_wb_we, m2_wb_we, 1'b0};
    assign b4_a  = '{m0_wb_4_burst, m1_wb_4_burst, m2_wb_4_burst, 1'b0};
    assign b8_a  = '{m0_wb_8_burst, m1_wb_8_burst, m2_wb_8_burst, 1'b0};
    assign adr_a = '{m0_wb_adr, m1_wb_adr, m2_wb_adr, 24'd0};
    assign dat_a = '{m0_wb_o_dat, m1_wb_o_dat, m2_wb_o_dat, 16'd0};
    assign sel_a = '{m0_wb_sel, m1_wb_sel, m2_wb_sel, 2'd0};
`ifdef WB_ARB_RR_EN
    logic [1:0] rr_q, rr_d;
    logic [2:0] idx;
    // Scan from the farthest candidate inward so the one nearest the pointer wins.
    always_comb begin
        win = 2'd0;
        idx = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            idx = {1'b0, rr_q} + 3'(i);
            idx = (idx >= 3'd3) ? idx - 3'd3 : idx;
            win = req[idx[1:0]] ? idx[1:0] : win;
        end
        rr_d = (state_q == IDLE && req[2:0] != 3'd0) ? ((win == 2'd2) ? 2'd0 : win + 2'd1) : rr_q;
    end
    always_ff @(posedge i_clk) begin
        rr_q <= i_rst ? 2'd0 : rr_d;
    end
`else
    assign win = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`endif
    always_comb begin
        own     = state_q == OWNED;
        sel_cyc = own & cyc_a[owner_q];
        sel_stb = sel_cyc & stb_a[owner_q];
        timeout = sel_stb & ~wb_ack & ~wb_err & (wdog_q == 8'(TIMEOUT_CYCLES - 1));
        wdog_d  = (!sel_cyc || wb_ack || wb_err || timeout) ? 8'd0 : sel_stb ? wdog_q + 8'd1 : wdog_q;
        state_d = own ? (sel_cyc ? OWNED : IDLE) : ((req[2:0] != 3'd0) ? OWNED : IDLE);
        owner_d = own ? owner_q : win;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
        end
    end
    assign wb_cyc     = sel_cyc & ~timeout;
    assign wb_stb     = sel_stb & ~timeout;
    assign wb_we      = own & we_a[owner_q];
    assign wb_4_burst = own & b4_a[owner_q];
    assign wb_8_burst = own & b8_a[owner_q];
    assign wb_adr     = adr_a[owner_q];
    assign wb_o_dat   = dat_a[owner_q];
    assign wb_sel     = sel_a[owner_q];
    assign o_owner    = own ? owner_q : 2'd3;
    assign ack_v      = own ? (3'(wb_ack) << owner_q) : 3'd0;
    assign err_v      = own ? (3'(wb_err | timeout) << owner_q) : 3'd0;
    assign {m2_wb_ack, m1_wb_ack, m0_wb_ack} = ack_v;
    assign {m2_wb_err, m1_wb_err, m0_wb_err} = err_v;
    assign m0_wb_i_dat = wb_i_dat;
    assign m1_wb_i_dat = wb_i_dat;
    assign m2_wb_i_dat = wb_i_dat;
endmodule
